// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - FSM state codes, size helpers and width check for conv_window_sequencer
package conv_seq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_FETCH  = 3'd1;
   localparam state_t ST_ISSUE  = 3'd2;
   localparam state_t ST_WAIT   = 3'd3;
   localparam state_t ST_OUTPUT = 3'd4;

   function automatic int out_size(input int image_size, input int kernel_size);
      return image_size - kernel_size + 1;
   endfunction

   function automatic int win_size(input int kernel_size);
      return kernel_size * kernel_size;
   endfunction

   // Both address buses must cover every pixel and every output position.
   function automatic bit addr_widths_ok(input int addr_width, input int out_addr_width,
                                         input int image_size, input int kernel_size);
      longint img_words;
      longint out_words;
      img_words = longint'(image_size) * longint'(image_size);
      out_words = longint'(out_size(image_size, kernel_size)) *
                  longint'(out_size(image_size, kernel_size));
      return ((longint'(1) << addr_width) >= img_words) &&
             ((longint'(1) << out_addr_width) >= out_words);
   endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// rtl/conv_seq_addr_gen.sv - output-position and window-offset counters with image/result address math
module conv_seq_addr_gen
   import conv_seq_pkg::*;
#(
   parameter int KERNEL_SIZE    = 5,
   parameter int IMAGE_SIZE     = 28,
   parameter int ADDR_WIDTH     = 10,
   parameter int OUT_ADDR_WIDTH = 10,
   parameter int CNT_W          = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pos_clear,
   input  logic                      pos_step,
   input  logic                      fetch_en,
   output logic [CNT_W-1:0]          fetch_cnt,
   output logic [ADDR_WIDTH-1:0]     img_addr,
   output logic [OUT_ADDR_WIDTH-1:0] res_addr,
   output logic                      last_pos
);
   localparam int KSQ      = win_size(KERNEL_SIZE);
   localparam int OUT_SIZE = out_size(IMAGE_SIZE, KERNEL_SIZE);
   localparam int PW       = $clog2(IMAGE_SIZE + 1);
   localparam int KW       = $clog2(KERNEL_SIZE + 1);

   logic [PW-1:0]    orow_q, orow_d, ocol_q, ocol_d;
   logic [KW-1:0]    kr_q, kr_d, kc_q, kc_d;
   logic [CNT_W-1:0] n_q, n_d;

   always_comb begin
      orow_d = orow_q;
      ocol_d = ocol_q;
      if (pos_clear) begin
         orow_d = '0;
         ocol_d = '0;
      end else if (pos_step) begin
         if (ocol_q == PW'(OUT_SIZE - 1)) begin
            ocol_d = '0;
            orow_d = orow_q + PW'(1);
         end else begin
            ocol_d = ocol_q + PW'(1);
         end
      end
   end

   // Window offsets restart whenever the FSM is outside FETCH.
   always_comb begin
      n_d  = n_q;
      kr_d = kr_q;
      kc_d = kc_q;
      if (!fetch_en) begin
         n_d  = '0;
         kr_d = '0;
         kc_d = '0;
      end else if (n_q < CNT_W'(KSQ)) begin
         n_d = n_q + CNT_W'(1);
         if (kc_q == KW'(KERNEL_SIZE - 1)) begin
            kc_d = '0;
            kr_d = kr_q + KW'(1);
         end else begin
            kc_d = kc_q + KW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         orow_q <= '0;
         ocol_q <= '0;
         kr_q   <= '0;
         kc_q   <= '0;
         n_q    <= '0;
      end else begin
         orow_q <= orow_d;
         ocol_q <= ocol_d;
         kr_q   <= kr_d;
         kc_q   <= kc_d;
         n_q    <= n_d;
      end
   end

   assign fetch_cnt = n_q;
   assign img_addr  = ADDR_WIDTH'((32'(orow_q) + 32'(kr_q)) * 32'(IMAGE_SIZE) +
                                  32'(ocol_q) + 32'(kc_q));
   assign res_addr  = OUT_ADDR_WIDTH'(32'(orow_q) * 32'(OUT_SIZE) + 32'(ocol_q));
   assign last_pos  = (orow_q == PW'(OUT_SIZE - 1)) && (ocol_q == PW'(OUT_SIZE - 1));

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - frame controller gathering KxK windows for the convolver
// Optional CONV_SEQ_RELU_EN clamps negative results to zero when latched.
module conv_window_sequencer
   import conv_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int KERNEL_SIZE    = 5,
   parameter int IMAGE_SIZE     = 28,
   parameter int ADDR_WIDTH     = 10,
   parameter int OUT_ADDR_WIDTH = 10
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       start,
   output logic                                       busy,
   output logic                                       frame_done,
   output logic                                       img_rd_en,
   output logic [ADDR_WIDTH-1:0]                      img_rd_addr,
   input  logic [DATA_WIDTH-1:0]                      img_rd_data,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] conv_pixel,
   output logic                                       conv_write,
   input  logic                                       conv_done,
   input  logic [DATA_WIDTH-1:0]                      conv_result,
   output logic                                       res_valid,
   input  logic                                       res_ready,
   output logic [DATA_WIDTH-1:0]                      res_data,
   output logic [OUT_ADDR_WIDTH-1:0]                  res_addr
);
   localparam int KSQ   = win_size(KERNEL_SIZE);
   localparam int CNT_W = $clog2(KSQ + 1);
   localparam int WIN_W = KSQ * DATA_WIDTH;

   if (!addr_widths_ok(ADDR_WIDTH, OUT_ADDR_WIDTH, IMAGE_SIZE, KERNEL_SIZE)) begin : g_bad_width
      $error("conv_window_sequencer: ADDR_WIDTH/OUT_ADDR_WIDTH too narrow for IMAGE_SIZE");
   end

   state_t                    state_q, state_d;
   logic [WIN_W-1:0]          conv_pixel_q, conv_pixel_d;
   logic [DATA_WIDTH-1:0]     res_data_q, res_data_d;
   logic [OUT_ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
   logic                      frame_done_q, frame_done_d;

   logic [CNT_W-1:0]          fetch_cnt;
   logic [ADDR_WIDTH-1:0]     gen_img_addr;
   logic [OUT_ADDR_WIDTH-1:0] gen_res_addr;
   logic                      last_pos;
   logic                      start_accept;
   logic                      handshake;
   logic [DATA_WIDTH-1:0]     result_in;

   assign start_accept = (state_q == ST_IDLE) && start;
   assign handshake    = (state_q == ST_OUTPUT) && res_ready;

`ifdef CONV_SEQ_RELU_EN
   assign result_in = conv_result[DATA_WIDTH-1] ? '0 : conv_result;
`else
   assign result_in = conv_result;
`endif

   conv_seq_addr_gen #(
      .KERNEL_SIZE   (KERNEL_SIZE),
      .IMAGE_SIZE    (IMAGE_SIZE),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .OUT_ADDR_WIDTH(OUT_ADDR_WIDTH),
      .CNT_W         (CNT_W)
   ) u_addr_gen (
      .clk      (clk),
      .reset    (reset),
      .pos_clear(start_accept),
      .pos_step (handshake),
      .fetch_en (state_q == ST_FETCH),
      .fetch_cnt(fetch_cnt),
      .img_addr (gen_img_addr),
      .res_addr (gen_res_addr),
      .last_pos (last_pos)
   );

   always_comb begin
      state_d      = state_q;
      conv_pixel_d = conv_pixel_q;
      res_data_d   = res_data_q;
      res_addr_d   = res_addr_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // RAM data lags the address by one cycle, so count n fills slot n-1.
            for (int i = 0; i < KSQ; i++) begin
               if (fetch_cnt == CNT_W'(i + 1)) conv_pixel_d[i*DATA_WIDTH +: DATA_WIDTH] = img_rd_data;
            end
            if (fetch_cnt == CNT_W'(KSQ)) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (conv_done) begin
               res_data_d = result_in;
               res_addr_d = gen_res_addr;
               state_d    = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (res_ready) begin
               if (last_pos) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         conv_pixel_q <= '0;
         res_data_q   <= '0;
         res_addr_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         conv_pixel_q <= conv_pixel_d;
         res_data_q   <= res_data_d;
         res_addr_q   <= res_addr_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign frame_done  = frame_done_q;
   assign img_rd_en   = (state_q == ST_FETCH) && (fetch_cnt < CNT_W'(KSQ));
   assign img_rd_addr = img_rd_en ? gen_img_addr : '0;
   assign conv_pixel  = conv_pixel_q;
   assign conv_write  = (state_q == ST_ISSUE);
   assign res_valid   = (state_q == ST_OUTPUT);
   assign res_data    = res_data_q;
   assign res_addr    = res_addr_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - scoreboard bench with ramp image RAM and convolver model
module tb_conv_window_sequencer;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          frame_done;
   logic          img_rd_en;
   logic [9:0]    img_rd_addr;
   logic [15:0]   img_rd_data = '0;
   logic [399:0]  conv_pixel;
   logic          conv_write;
   logic          conv_done;
   logic [15:0]   conv_result;
   logic          res_valid;
   logic          res_ready;
   logic [15:0]   res_data;
   logic [9:0]    res_addr;

   int            checks = 0;
   int            errors = 0;
   logic [15:0]   sbq_data[$];
   logic [9:0]    sbq_addr[$];
   int            pos = 0;
   int            hs_count = 0;
   int            fd_count = 0;
   logic [15:0]   last_slot0 = '0;
   logic [15:0]   last_slot24 = '0;
   logic [9:0]    last_hs_addr = '0;
   int            conv_lat = 1;
   bit            force_en = 1'b0;
   logic [15:0]   force_val = '0;
   int            inject_total = 0;

`ifdef CONV_SEQ_RELU_EN
   localparam logic [15:0] NEG_EXP = 16'h0000;
`else
   localparam logic [15:0] NEG_EXP = 16'hFFFB;
`endif

   always #5 clk = ~clk;

   conv_window_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .img_rd_en  (img_rd_en),
      .img_rd_addr(img_rd_addr),
      .img_rd_data(img_rd_data),
      .conv_pixel (conv_pixel),
      .conv_write (conv_write),
      .conv_done  (conv_done),
      .conv_result(conv_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_addr   (res_addr)
   );

   // Ramp image: pixel[a] = a
   always @(posedge clk) if (img_rd_en) img_rd_data <= 16'(img_rd_addr);

   function automatic logic [15:0] slot(input int i);
      return conv_pixel[i*16 +: 16];
   endfunction

   function automatic logic [15:0] exp_result(input int p);
      logic [15:0] v;
      int s;
      if (force_en) begin
         v = force_val;
      end else begin
         s = 0;
         for (int kr = 0; kr < 5; kr++)
            for (int kc = 0; kc < 5; kc++)
               s += (p / 24 + kr) * 28 + (p % 24) + kc;
         v = 16'(s);
      end
`ifdef CONV_SEQ_RELU_EN
      if (v[15]) v = 16'h0000;
`endif
      return v;
   endfunction

   // Convolver: sums the window, answers conv_lat cycles after conv_write
   initial begin : conv_model
      int pending;
      int inj_done;
      logic [15:0] acc;
      pending = 0;
      inj_done = 0;
      acc = '0;
      conv_done = 1'b0;
      conv_result = '0;
      forever begin
         @(posedge clk);
         #1;
         conv_done = 1'b0;
         if (pending > 0) begin
            pending--;
            if (pending == 0) begin
               conv_done = 1'b1;
               conv_result = force_en ? force_val : acc;
            end
         end
         if (inj_done != inject_total) begin
            conv_done = 1'b1;
            conv_result = 16'h7777;
            inj_done++;
         end
         if (conv_write) begin
            acc = '0;
            for (int i = 0; i < 25; i++) acc += slot(i);
            pending = conv_lat;
         end
      end
   end

   task automatic tick();
      logic [15:0] ed;
      logic [9:0]  ea;
      @(negedge clk);
      if (!reset) begin
         sbq_data.delete();
         sbq_addr.delete();
         pos = 0;
      end else begin
         if (conv_write) begin
            sbq_data.push_back(exp_result(pos));
            sbq_addr.push_back(10'(pos));
            if (pos == 575) begin
               last_slot0  = slot(0);
               last_slot24 = slot(24);
            end
         end
         if (res_valid && res_ready) begin
            checks++;
            if (sbq_data.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: handshake res_addr=%0d with no expected result", res_addr);
            end else begin
               ed = sbq_data.pop_front();
               ea = sbq_addr.pop_front();
               if (res_data !== ed || res_addr !== ea) begin
                  errors++;
                  $display("FAIL sb_result: got data=%h addr=%0d, expected data=%h addr=%0d",
                           res_data, res_addr, ed, ea);
               end
            end
            hs_count++;
            last_hs_addr = res_addr;
            pos = (pos == 575) ? 0 : pos + 1;
         end
         if (frame_done) fd_count++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if ({busy, frame_done, img_rd_en, conv_write, res_valid} !== 5'b0 || img_rd_addr !== '0 ||
          conv_pixel !== '0 || res_data !== '0 || res_addr !== '0) begin
         errors++;
         $display("FAIL reset_init: got ctl=%b addr=%0d res=%h/%0d, expected all 0",
                  {busy, frame_done, img_rd_en, conv_write, res_valid}, img_rd_addr, res_data, res_addr);
      end
      reset = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      checks++;
      if (busy !== 1'b1 || img_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_fetch: got busy=%b rd_en=%b, expected 1/1", busy, img_rd_en);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({busy, frame_done, img_rd_en, conv_write, res_valid} !== 5'b0 || img_rd_addr !== '0 ||
             conv_pixel !== '0 || res_data !== '0 || res_addr !== '0) begin
            errors++;
            $display("FAIL reset_hold: cycle %0d got ctl=%b addr=%0d pix_nonzero=%b, expected all 0",
                     i, {busy, frame_done, img_rd_en, conv_write, res_valid}, img_rd_addr, |conv_pixel);
         end
      end
      reset = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || img_rd_en !== 1'b1 || img_rd_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_restart: got busy=%b rd_en=%b addr=%0d, expected 1/1/0", busy, img_rd_en, img_rd_addr);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_first_position();
      int cyc;
      res_ready = 1'b1;
      conv_lat = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (!conv_write && cyc < 40) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc !== 27) begin
         errors++;
         $display("FAIL conv_write_cycle: got cycle %0d, expected 27", cyc);
      end
      checks++;
      if (slot(0) !== 16'd0 || slot(4) !== 16'd4 || slot(5) !== 16'd28 || slot(24) !== 16'd116) begin
         errors++;
         $display("FAIL first_window: got %0d/%0d/%0d/%0d, expected 0/4/28/116",
                  slot(0), slot(4), slot(5), slot(24));
      end
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL res_valid_early: got %b in cycle 28, expected 0", res_valid);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_addr !== 10'd0) begin
         errors++;
         $display("FAIL res_valid_cycle: got valid=%b addr=%0d in cycle 29, expected 1/0", res_valid, res_addr);
      end
   endtask

   task automatic test_full_frame();
      int n;
      n = 0;
      while (fd_count == 0 && n < 25000) begin
         tick();
         n++;
      end
      checks++;
      if (fd_count !== 1) begin
         errors++;
         $display("FAIL frame_done_seen: got %0d pulses, expected 1", fd_count);
      end
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_end_state: got frame_done=%b busy=%b, expected 0/0", frame_done, busy);
      end
      checks++;
      if (hs_count !== 576) begin
         errors++;
         $display("FAIL handshake_count: got %0d, expected 576", hs_count);
      end
      checks++;
      if (last_slot0 !== 16'd667 || last_slot24 !== 16'd783 || last_hs_addr !== 10'd575) begin
         errors++;
         $display("FAIL last_position: got slot0=%0d slot24=%0d addr=%0d, expected 667/783/575",
                  last_slot0, last_slot24, last_hs_addr);
      end
      repeat (3) tick();
      checks++;
      if (fd_count !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_done_single: got pulses=%0d busy=%b, expected 1/0", fd_count, busy);
      end
      res_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      logic [15:0] exp0;
      exp0 = exp_result(0);
      res_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!res_valid && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid_timeout: got res_valid=%b, expected 1", res_valid);
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 2 || i == 5) inject_total++;
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_data !== exp0 || res_addr !== 10'd0 || img_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d got valid=%b data=%h addr=%0d rd_en=%b, expected 1/%h/0/0",
                     i, res_valid, res_data, res_addr, img_rd_en, exp0);
         end
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b1 || hs_count !== 577) begin
         errors++;
         $display("FAIL bp_release: got valid=%b busy=%b handshakes=%0d, expected 0/1/577",
                  res_valid, busy, hs_count);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_relu();
      int n;
      force_en = 1'b1;
      force_val = 16'hFFFB;
      res_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!res_valid && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_data !== NEG_EXP) begin
         errors++;
         $display("FAIL relu_negative: got valid=%b data=%h, expected 1/%h", res_valid, res_data, NEG_EXP);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      force_val = 16'h0100;
      n = 0;
      while (!res_valid && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h0100 || res_addr !== 10'd1) begin
         errors++;
         $display("FAIL relu_positive: got valid=%b data=%h addr=%0d, expected 1/0100/1",
                  res_valid, res_data, res_addr);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      force_en = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_busy_wait_reset();
      int n;
      conv_lat = 12;
      res_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!conv_write && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (conv_write !== 1'b1) begin
         errors++;
         $display("FAIL wait_issue_timeout: got conv_write=%b, expected 1", conv_write);
      end
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (busy !== 1'b1 || conv_write !== 1'b0 || img_rd_en !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_start_ignored: cycle %0d got busy=%b wr=%b rd_en=%b valid=%b, expected 1/0/0/0",
                     i, busy, conv_write, img_rd_en, res_valid);
         end
      end
      n = 0;
      while (!res_valid && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_addr !== 10'd0 || res_data !== exp_result(0)) begin
         errors++;
         $display("FAIL wait_result: got valid=%b addr=%0d data=%h, expected 1/0/%h",
                  res_valid, res_addr, res_data, exp_result(0));
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n = 0;
      while (!conv_write && n < 60) begin
         tick();
         n++;
      end
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_done_ignored: cycle %0d got busy=%b valid=%b, expected 0/0", i, busy, res_valid);
         end
      end
      conv_lat = 1;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      res_ready = 1'b0;
      test_reset();
      test_first_position();
      test_full_frame();
      test_backpressure();
      test_relu();
      test_busy_wait_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Frame-level controller for the 5x5 convolver datapath. On a start pulse it walks every valid output position of an IMAGE_SIZE x IMAGE_SIZE image held in a synchronous image RAM, gathers the KERNEL_SIZE² pixel window into the convolver's packed pixel bus, and fires the convolver's write strobe. It then waits for the convolver's result strobe and hands each result downstream over a valid/ready port. It sits between the image buffer and the convolver; weights and bias stay driven by the layer configuration logic.

## Interface

Parameters:
- DATA_WIDTH, 16, pixel/result word width (signed, FRAC_BIT fractional bits; not interpreted here)
- KERNEL_SIZE, 5, window edge
- IMAGE_SIZE, 28, image edge
- ADDR_WIDTH, 10, image RAM address width (≥ clog2(IMAGE_SIZE²))
- OUT_ADDR_WIDTH, 10, result index width (≥ clog2(OUT_SIZE²)); OUT_SIZE = IMAGE_SIZE-KERNEL_SIZE+1 = 24

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last result handshake
- img_rd_en  out  1  image RAM read enable
- img_rd_addr  out  ADDR_WIDTH  row-major pixel address
- img_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after img_rd_en
- conv_pixel  out  KERNEL_SIZE²·DATA_WIDTH  window; slot i=kr·K+kc at [i·DATA_WIDTH +: DATA_WIDTH]
- conv_write  out  1  one-cycle pulse: window valid
- conv_done  in  1  convolver result strobe (its enable_signal)
- conv_result  in  DATA_WIDTH  convolver result, valid with conv_done
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts
- res_data  out  DATA_WIDTH  result
- res_addr  out  OUT_ADDR_WIDTH  orow·OUT_SIZE+ocol

## Operation

- States: IDLE, FETCH, ISSUE, WAIT, OUTPUT.
- IDLE: start=1 → FETCH; orow=ocol=0, fetch counter=0.
- FETCH: counter n=0..K² (26 cycles for K=5). For n<K²: img_rd_en=1, addr=(orow+n/K)·IMAGE_SIZE+(ocol+n%K). For n≥1: slot n-1 ← img_rd_data. At n=K² → ISSUE.
- ISSUE: conv_write=1 for exactly one cycle → WAIT.
- WAIT: conv_done=1 → latch conv_result and res_addr, → OUTPUT. conv_done outside WAIT is ignored.
- OUTPUT: res_valid=1. res_data and res_addr are held stable until res_ready=1. On handshake: if ocol<OUT_SIZE-1, ocol++. Else ocol=0 and orow++. If the position was (OUT_SIZE-1, OUT_SIZE-1): frame_done pulse, → IDLE; else → FETCH.
- Full window refetch per position; no column reuse.
- conv_pixel holds its value from the end of FETCH until overwritten in the next FETCH.
- start while busy is ignored. Reset in any state: → IDLE, all counters cleared.

## Timing

- Reset values: busy, frame_done, img_rd_en, conv_write, res_valid = 0. img_rd_addr, conv_pixel, res_data, res_addr = 0.
- Start sampled in cycle 0. FETCH occupies cycles 1–26 and issues reads in cycles 1–25. conv_write is high in cycle 27.
- Convolver latency L ≥ 1: conv_done no earlier than cycle 28. res_valid asserts the cycle after conv_done.
- Per position: K²+1 + 1 + L + 1 cycles minimum, with res_ready held high.
- Address arithmetic is unsigned; the address never exceeds IMAGE_SIZE²-1.

## Configuration

- CONV_SEQ_RELU_EN defined: the latched result is clamped, so res_data = (conv_result<0) ? 0 : conv_result.
- Undefined: res_data = conv_result unchanged.
- Either way, no effect on timing.

## Structure

- Package conv_seq_pkg holds:
  - state enum
  - OUT_SIZE and K² localparam helpers
  - the address-width sanity check
- Sub-module conv_seq_addr_gen holds the orow/ocol/kr/kc counters and the image/result address computation. The FSM, window register and result register stay in the top.

## Test plan

- Reset: hold reset=0 for 3 cycles mid-FETCH → all outputs 0, busy=0; start is accepted on the next cycle after release.
- Ramp image (pixel[a]=a), position (0,0): conv_write in cycle 27 after start; slot0=0, slot4=4, slot5=28, slot24=116.
- Ramp image, last position: res_addr=575, slot0=667, slot24=783. Completing a frame gives exactly 576 handshakes, then one frame_done pulse and busy=0 the following cycle.
- Backpressure: res_ready=0 for 10 cycles → res_valid stays 1, res_data/res_addr stable, img_rd_en=0 throughout. Two conv_done pulses injected during OUTPUT are ignored.
- Result clamping: conv_result=16'hFFFB → res_data=0 with CONV_SEQ_RELU_EN, 16'hFFFB without. conv_result=16'h0100 → 16'h0100 in both builds.
- Busy/reset: a start pulse during WAIT changes nothing. Reset asserted in WAIT, then a late conv_done → block stays IDLE, res_valid=0.
